// File: rtl/fifo_rd_unpacker.sv
// fifo_rd_unpacker
// Pops DWIDTH-bit words from a fall-through FIFO and streams each one out as
// BEATS = DWIDTH/OWIDTH narrower beats over a valid/ready handshake, least
// significant slice first. The next word is popped on the same cycle that the
// last beat of the current word is accepted, so a full FIFO streams with no
// bubbles. word_cnt counts fully transmitted words and wraps at 16 bits.

module fifo_rd_unpacker #(
    parameter int DWIDTH = 40,
    parameter int OWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              fifo_empty,
    input  logic [DWIDTH-1:0] fifo_rd,
    output logic              fifo_rden,
    output logic              m_valid,
    output logic [OWIDTH-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    output logic [15:0]       word_cnt
);

    localparam int BEATS = DWIDTH / OWIDTH;
    // A one-beat word still needs a one-bit counter so the compare is legal.
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [DWIDTH-1:0] shift_q;
    logic [DWIDTH-1:0] shift_d;
    logic [CNT_W-1:0]  beat_q;
    logic [CNT_W-1:0]  beat_d;
    logic              handshake;

    // Output view of the held word plus the pop strobe; the pop is allowed
    // when nothing is held or when the final beat is leaving this cycle.
    always_comb begin
        m_valid   = (state_q == SEND);
        m_last    = m_valid && (beat_q == LAST_BEAT);
        m_data    = shift_q[OWIDTH-1:0];
        handshake = m_valid && m_ready;
        fifo_rden = !rst && en && !fifo_empty &&
                    ((state_q == IDLE) || (handshake && m_last));
    end

    // Next-state logic: a pop always reloads, otherwise an accepted beat either
    // advances within the word or, on the last beat, releases it.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        beat_d  = beat_q;
        if (fifo_rden) begin
            state_d = SEND;
            shift_d = fifo_rd;
            beat_d  = '0;
        end else if (handshake) begin
            if (m_last) begin
                state_d = IDLE;
            end else begin
                shift_d = shift_q >> OWIDTH;
                beat_d  = beat_q + CNT_W'(1);
            end
        end
    end

    // State, shift register and beat counter; reset discards any partial word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            beat_q  <= beat_d;
        end
    end

    // Completed-word counter, bumped when the last beat of a word is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt <= '0;
        end else if (handshake && m_last) begin
            word_cnt <= word_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_fifo_rd_unpacker.sv
// Testbench for fifo_rd_unpacker: a 40/8 instance driven by directed and random
// traffic against a word-level reference model, plus a 1-beat instance that
// runs long enough to wrap the 16-bit completed-word counter.

module tb_fifo_rd_unpacker;

    localparam int DW    = 40;
    localparam int OW    = 8;
    localparam int BEATS = DW / OW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance signals
    logic          rst;
    logic          en;
    logic          fifo_empty;
    logic [DW-1:0] fifo_rd;
    logic          fifo_rden;
    logic          m_valid;
    logic [OW-1:0] m_data;
    logic          m_last;
    logic          m_ready;
    logic [15:0]   word_cnt;

    // Single-beat instance signals
    logic          rst2;
    logic          en2;
    logic          fifo_empty2;
    logic [7:0]    fifo_rd2;
    logic          fifo_rden2;
    logic          m_valid2;
    logic [7:0]    m_data2;
    logic          m_last2;
    logic          m_ready2;
    logic [15:0]   word_cnt2;

    fifo_rd_unpacker #(.DWIDTH(DW), .OWIDTH(OW)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_rd    (fifo_rd),
        .fifo_rden  (fifo_rden),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_last     (m_last),
        .m_ready    (m_ready),
        .word_cnt   (word_cnt)
    );

    fifo_rd_unpacker #(.DWIDTH(8), .OWIDTH(8)) dut1 (
        .clk        (clk),
        .rst        (rst2),
        .en         (en2),
        .fifo_empty (fifo_empty2),
        .fifo_rd    (fifo_rd2),
        .fifo_rden  (fifo_rden2),
        .m_valid    (m_valid2),
        .m_data     (m_data2),
        .m_last     (m_last2),
        .m_ready    (m_ready2),
        .word_cnt   (word_cnt2)
    );

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;
    bit wrapDone   = 1'b0;

    // Reference model: queued FIFO contents, the word in flight and how many
    // of its beats remain, and the expected completed-word count.
    logic [DW-1:0] fifoQ[$];
    logic [DW-1:0] curWord   = '0;
    int            beatsLeft = 0;
    logic [15:0]   expWordCnt = '0;

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     tag, actual, expected, $time);
        end
    endtask

    task automatic refreshFifo();
        fifo_empty = (fifoQ.size() == 0);
        fifo_rd    = fifo_empty ? '0 : fifoQ[0];
    endtask

    task automatic pushWord(input logic [DW-1:0] w);
        fifoQ.push_back(w);
        refreshFifo();
    endtask

    // One clock cycle: drive en/m_ready, compare outputs against the model,
    // then advance the model across the rising edge.
    task automatic applyStimulus(input logic enV, input logic readyV);
        logic          expValid;
        logic          expLast;
        logic          expRden;
        logic [DW-1:0] slice;
        en      = enV;
        m_ready = readyV;
        #1;
        expValid = (beatsLeft > 0);
        expLast  = (beatsLeft == 1);
        expRden  = enV && (fifoQ.size() > 0) &&
                   ((beatsLeft == 0) || (beatsLeft == 1 && readyV));
        checkOutput("fifo_rden", 64'(fifo_rden), 64'(expRden));
        checkOutput("m_valid",   64'(m_valid),   64'(expValid));
        checkOutput("m_last",    64'(m_last),    64'(expLast));
        checkOutput("word_cnt",  64'(word_cnt),  64'(expWordCnt));
        if (expValid) begin
            slice = curWord >> (OW * (BEATS - beatsLeft));
            checkOutput("m_data", 64'(m_data), 64'(slice[OW-1:0]));
        end
        @(posedge clk);
        #1;
        if (expValid && readyV) begin
            beatsLeft--;
            if (beatsLeft == 0) expWordCnt++;
        end
        if (expRden) begin
            curWord   = fifoQ.pop_front();
            beatsLeft = BEATS;
            refreshFifo();
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        #1;
        checkOutput("rst_m_valid",   64'(m_valid),   64'd0);
        checkOutput("rst_m_last",    64'(m_last),    64'd0);
        checkOutput("rst_m_data",    64'(m_data),    64'd0);
        checkOutput("rst_fifo_rden", 64'(fifo_rden), 64'd0);
        checkOutput("rst_word_cnt",  64'(word_cnt),  64'd0);
        beatsLeft  = 0;
        expWordCnt = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [DW-1:0] randWord();
        return {$urandom(), $urandom()};
    endfunction

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main instance: directed scenarios followed by random traffic.
    initial begin
        rst = 1'b1;
        en = 1'b0;
        m_ready = 1'b0;
        refreshFifo();
        @(posedge clk);
        #1;
        doReset();

        // Idle gating: empty FIFO with en=1, then data present with en=0.
        repeat (4) applyStimulus(1'b1, 1'b1);
        pushWord(40'h44_33_22_11_00);
        repeat (4) applyStimulus(1'b0, 1'b1);

        // Single word streamed out as 00,11,22,33,44.
        repeat (8) applyStimulus(1'b1, 1'b1);
        checkOutput("single_word_cnt", 64'(word_cnt), 64'd1);

        // Three words back to back with no gaps.
        repeat (3) pushWord(randWord());
        repeat (18) applyStimulus(1'b1, 1'b1);
        checkOutput("b2b_word_cnt", 64'(word_cnt), 64'd4);

        // Backpressure pattern 1,0,0 repeated.
        repeat (2) pushWord(randWord());
        for (int i = 0; i < 40; i++) applyStimulus(1'b1, (i % 3) == 0);

        // en dropped after the second beat: word still finishes, no new pop.
        repeat (2) pushWord(randWord());
        repeat (3) applyStimulus(1'b1, 1'b1);
        repeat (10) applyStimulus(1'b0, 1'b1);
        repeat (6) applyStimulus(1'b1, 1'b1);

        // Reset after the second beat of a word, then a fresh word.
        repeat (2) pushWord(randWord());
        repeat (3) applyStimulus(1'b1, 1'b1);
        doReset();
        checkOutput("post_rst_word_cnt", 64'(word_cnt), 64'd0);
        repeat (8) applyStimulus(1'b1, 1'b1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if (($urandom % 3) == 0 && fifoQ.size() < 8) pushWord(randWord());
            if (($urandom % 300) == 0) doReset();
            applyStimulus(($urandom % 8) != 0, ($urandom % 4) != 0);
        end

        for (int i = 0; i < 80000 && !wrapDone; i++) @(posedge clk);
        if (!wrapDone) checkOutput("wrap_timeout", 64'd0, 64'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    // Single-beat instance: every beat is a whole word, so with a full FIFO
    // and m_ready held high one word completes per cycle until the wrap.
    initial begin
        int unsigned doneCnt;
        bit          busy;
        doneCnt     = 0;
        busy        = 1'b0;
        rst2        = 1'b1;
        en2         = 1'b1;
        m_ready2    = 1'b1;
        fifo_empty2 = 1'b1;
        fifo_rd2    = 8'h5A;
        @(posedge clk);
        #1;
        checkOutput("w1_rst_valid", 64'(m_valid2), 64'd0);
        rst2        = 1'b0;
        fifo_empty2 = 1'b0;
        while (doneCnt < 65536) begin
            if (doneCnt == 3) begin
                checkOutput("w1_cnt3",   64'(word_cnt2), 64'd3);
                checkOutput("w1_last",   64'(m_last2),   64'd1);
                checkOutput("w1_data",   64'(m_data2),   64'h5A);
                checkOutput("w1_rden",   64'(fifo_rden2), 64'd1);
            end
            if (doneCnt == 65535) checkOutput("wrap_pre", 64'(word_cnt2), 64'hFFFF);
            @(posedge clk);
            #1;
            if (busy) doneCnt++;
            busy = 1'b1;
        end
        checkOutput("wrap_zero",  64'(word_cnt2), 64'd0);
        checkOutput("wrap_valid", 64'(m_valid2),  64'd1);
        wrapDone = 1'b1;
    end

endmodule
